serial_frame_generator: RTL and testbench

Transmit-side counterpart of the team's serial sequence detectors. Accepts one parallel word over a valid/ready handshake and emits it on a single serial line as a frame: a fixed preamble, then the payload MSB-first, then an optional even-parity bit, then a guard gap of zeros. Frames never overlap, so a non-overlapping detector on the far end sees exactly one preamble per frame. Sits between a word source and the serial line driving the detector.

---
 rtl/serial_frame_generator_pkg.sv | 28 ++
 rtl/serial_frame_generator_if.sv | 11 +
 rtl/serial_frame_generator.sv | 109 ++++++++++
 tb/tb_serial_frame_generator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_generator_pkg.sv
// Shared definitions for the serial frame generator and its matching detector.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAR,
    GAP
  } state_t;

  // Framing constants shared with the far-end detector.
  localparam int unsigned DEF_PRE_W = 3;
  localparam logic [DEF_PRE_W-1:0] DEF_PREAMBLE = 3'b100;
  localparam int unsigned DEF_GAP_W = 2;

  // Bit counter width: enough to hold the longest phase length minus one.
  function automatic int unsigned cnt_width(input int unsigned pre_w,
                                            input int unsigned data_w,
                                            input int unsigned gap_w);
    int unsigned m;
    m = pre_w;
    if (data_w > m) m = data_w;
    if (gap_w > m) m = gap_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_frame_generator_if.sv
// Word-source handshake into the serial frame generator.
interface serial_frame_generator_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_frame_generator.sv
// Serialises one accepted word per frame: preamble, payload MSB-first,
// optional even parity, then a guard gap of zeros.
module serial_frame_generator
  import serial_frame_pkg::*;
#(
  parameter int unsigned        PRE_W     = DEF_PRE_W,
  parameter logic [PRE_W-1:0]   PREAMBLE  = DEF_PREAMBLE,
  parameter int unsigned        DATA_W    = 8,
  parameter bit                 PARITY_EN = 1'b0,
  parameter int unsigned        GAP_W     = DEF_GAP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_frame_generator_if.slave  src,
  output logic                     sout,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned SW = PRE_W + DATA_W;
  localparam int unsigned CW = cnt_width(PRE_W, DATA_W, GAP_W);

  state_t          state;
  logic [SW-1:0]   sr;
  logic [CW-1:0]   cnt;
  logic            par;
  logic [SW-1:0]   load;
  logic            accept;

  assign load         = {PREAMBLE, src.in_data};
  assign src.in_ready = (state == IDLE) & ~rst;
  assign accept       = src.in_valid & src.in_ready;
  assign busy         = (state != IDLE);

  // Frame FSM, shift register and bit counter. sout is registered one step
  // ahead: each transition drives the bit that belongs to the state being
  // entered, so the first preamble bit is loaded straight into sout on accept
  // and the shift register keeps the remaining bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      sout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          sout <= 1'b0;
          if (accept) begin
            sout  <= PREAMBLE[PRE_W-1];
            sr    <= load << 1;
            par   <= ^src.in_data;
            cnt   <= CW'(PRE_W - 1);
            state <= PRE;
          end
        end
        PRE: begin
          sout <= sr[SW-1];
          sr   <= {sr[SW-2:0], 1'b0};
          if (cnt == '0) begin
            cnt   <= CW'(DATA_W - 1);
            state <= DATA;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            if (PARITY_EN) begin
              sout  <= par;
              state <= PAR;
            end else begin
              sout       <= 1'b0;
              frame_done <= 1'b1;
              cnt        <= CW'(GAP_W - 1);
              state      <= GAP;
            end
          end else begin
            sout <= sr[SW-1];
            sr   <= {sr[SW-2:0], 1'b0};
            cnt  <= cnt - CW'(1);
          end
        end
        PAR: begin
          sout       <= 1'b0;
          frame_done <= 1'b1;
          cnt        <= CW'(GAP_W - 1);
          state      <= GAP;
        end
        GAP: begin
          sout <= 1'b0;
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          sout  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_generator.sv
// Directed bench for serial_frame_generator: table of frames on a
// no-parity and a parity instance, plus multi-cycle corner sequences and a
// loopback into a frame-aware detector model.
module tb_serial_frame_generator;
  import serial_frame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sout0, busy0, done0;
  logic sout1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  serial_frame_generator_if #(.DATA_W(8)) if0 ();
  serial_frame_generator_if #(.DATA_W(8)) if1 ();

  serial_frame_generator #(.DATA_W(8), .PARITY_EN(1'b0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .src        (if0.slave),
    .sout       (sout0),
    .busy       (busy0),
    .frame_done (done0)
  );

  serial_frame_generator #(.DATA_W(8), .PARITY_EN(1'b1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .src        (if1.slave),
    .sout       (sout1),
    .busy       (busy1),
    .frame_done (done1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    bit          par;
    logic [1:15] seq;      // sout in cycles N+1..N+15
    int unsigned done_k;   // cycle offset of the frame_done pulse
    int unsigned ready_k;  // cycle offset where in_ready returns
  } vec_t;

  vec_t vecs[5];

  // Loopback detector model state
  logic        det_en  = 1'b0;
  logic        det_pay = 1'b0;
  logic [2:0]  win     = '0;
  logic [7:0]  rxw     = '0;
  int          bitcnt  = 0;
  int          det_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  rx_words[20];
  logic [7:0]  exp_words[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] obs(input bit p);
    return p ? {sout1, done1, if1.in_ready, busy1}
             : {sout0, done0, if0.in_ready, busy0};
  endfunction

  function automatic logic [1:15] frame_seq(input logic [7:0] d, input bit p);
    logic [1:15] s;
    s = '0;
    s[1] = 1'b1;
    for (int unsigned i = 0; i < 8; i++) s[4+i] = d[7-i];
    if (p) s[12] = ^d;
    return s;
  endfunction

  task automatic drive(input bit p, input logic v, input logic [7:0] d);
    if (p) begin
      if1.in_valid = v;
      if1.in_data  = d;
    end else begin
      if0.in_valid = v;
      if0.in_data  = d;
    end
  endtask

  // Called at a negedge with the selected instance idle.
  task automatic run_frame(input bit p, input logic [7:0] d, input logic [1:15] seq,
                           input int unsigned done_k, input int unsigned ready_k,
                           input string tag);
    logic [3:0] o;
    drive(p, 1'b1, d);
    o = obs(p);
    chk($sformatf("%s ready@N", tag), 32'(o[1]), 32'd1);
    for (int unsigned k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) drive(p, 1'b0, d);
      o = obs(p);
      chk($sformatf("%s sout k=%0d", tag, k), 32'(o[3]), 32'(seq[k]));
      chk($sformatf("%s done k=%0d", tag, k), 32'(o[2]), 32'(k == done_k));
      chk($sformatf("%s ready k=%0d", tag, k), 32'(o[1]), 32'(k >= ready_k));
      chk($sformatf("%s busy k=%0d", tag, k), 32'(o[0]), 32'(k < ready_k));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(if0.in_ready && if1.in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s idle", tag), 32'(if0.in_ready && if1.in_ready), 32'd1);
  endtask

  // Frame-aware detector: hunts for the preamble, then takes the payload.
  always @(negedge clk) begin
    if (det_en) begin
      if (done0) done_cnt <= done_cnt + 1;
      if (!det_pay) begin
        if ({win[1:0], sout0} == DEF_PREAMBLE) begin
          det_pay <= 1'b1;
          bitcnt  <= 0;
          win     <= '0;
        end else begin
          win <= {win[1:0], sout0};
        end
      end else begin
        rxw <= {rxw[6:0], sout0};
        if (bitcnt == 7) begin
          if (det_cnt < 20) rx_words[det_cnt] <= {rxw[6:0], sout0};
          det_cnt <= det_cnt + 1;
          det_pay <= 1'b0;
        end else begin
          bitcnt <= bitcnt + 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:15] s;
    int          c2;
    bit          found;

    vecs[0] = '{8'hA5, 1'b0, 15'b100101001010000, 12, 14};
    vecs[1] = '{8'h07, 1'b1, 15'b100000001111000, 13, 15};
    vecs[2] = '{8'hFF, 1'b0, 15'b100111111110000, 12, 14};
    vecs[3] = '{8'h3C, 1'b1, 15'b100001111000000, 13, 15};
    vecs[4] = '{8'h00, 1'b0, 15'b100000000000000, 12, 14};

    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst sout0",  32'(sout0), 32'd0);
    chk("rst busy0",  32'(busy0), 32'd0);
    chk("rst done0",  32'(done0), 32'd0);
    chk("rst ready0", 32'(if0.in_ready), 32'd0);
    chk("rst sout1",  32'(sout1), 32'd0);
    chk("rst ready1", 32'(if1.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].par, vecs[i].data, vecs[i].seq, vecs[i].done_k,
                vecs[i].ready_k, $sformatf("vec%0d", i));
    end

    // Back-to-back: FF then 00 with in_valid held
    drive(1'b0, 1'b1, 8'hFF);
    chk("b2b ready@N", 32'(if0.in_ready), 32'd1);
    s = frame_seq(8'hFF, 1'b0);
    c2 = 0;
    found = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b1, 8'h00);
      if (c <= 3) chk($sformatf("b2b pre1 c=%0d", c), 32'(sout0), 32'(s[c]));
      if (if0.in_ready) begin
        found = 1'b1;
        c2 = c;
      end
    end
    chk("b2b interval", 32'(c2), 32'd14);
    s = frame_seq(8'h00, 1'b0);
    for (int unsigned j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1) drive(1'b0, 1'b0, 8'h00);
      chk($sformatf("b2b frame2 j=%0d", j), 32'(sout0), 32'(s[j]));
    end
    wait_idle("b2b");

    // Pending word with toggling data during a frame in flight
    s = frame_seq(8'hA5, 1'b0);
    drive(1'b0, 1'b1, 8'hA5);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 8'hA5);
      if (k <= 13) chk($sformatf("pend sout k=%0d", k), 32'(sout0), 32'(s[k]));
      chk($sformatf("pend ready k=%0d", k), 32'(if0.in_ready), 32'(k == 14));
      if (k >= 3) drive(1'b0, 1'b1, k[0] ? 8'h5A : 8'h81);
    end
    s = frame_seq(8'h81, 1'b0);
    for (int unsigned j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1) drive(1'b0, 1'b0, 8'h00);
      chk($sformatf("pend frame2 j=%0d", j), 32'(sout0), 32'(s[j]));
    end
    wait_idle("pend");

    // Reset during DATA of C3
    drive(1'b0, 1'b1, 8'hC3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 8'hC3);
    end
    chk("midrst busy before", 32'(busy0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst sout",  32'(sout0), 32'd0);
    chk("midrst busy",  32'(busy0), 32'd0);
    chk("midrst done",  32'(done0), 32'd0);
    chk("midrst ready", 32'(if0.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst ready after", 32'(if0.in_ready), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst quiet done k=%0d", k), 32'(done0), 32'd0);
      chk($sformatf("midrst quiet sout k=%0d", k), 32'(sout0), 32'd0);
    end
    run_frame(1'b0, 8'h3C, frame_seq(8'h3C, 1'b0), 12, 14, "postrst");

    // Loopback of 20 random words into the detector model
    det_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_words[i] = 8'($urandom_range(0, 255));
      begin
        int n;
        n = 0;
        while (!if0.in_ready && n < 40) begin
          @(negedge clk);
          n++;
        end
      end
      chk($sformatf("loop ready w%0d", i), 32'(if0.in_ready), 32'd1);
      drive(1'b0, 1'b1, exp_words[i]);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00);
    end
    wait_idle("loop");
    repeat (3) @(negedge clk);
    det_en = 1'b0;
    @(negedge clk);
    chk("loop detections", 32'(det_cnt), 32'd20);
    chk("loop frame_done count", 32'(done_cnt), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < det_cnt) chk($sformatf("loop word %0d", i), 32'(rx_words[i]), 32'(exp_words[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
